// File: rtl/word_packer_pkg.sv
// word_packer_pkg: shared types and helper functions for word_packer.
//   state_t    - packer FSM state (FILL accepting words, HOLD presenting a block)
//   ptr_bits   - width of the word pointer / slot address for a given N_REG
//   cnt_bits   - width of the word count (must represent 0..N_REG)
//   slot_index - physical slot written for a logical word position
package word_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int ptr_bits(input int n_reg);
    return (n_reg == 1) ? 1 : $clog2(n_reg);
  endfunction

  function automatic int cnt_bits(input int n_reg);
    return $clog2(n_reg + 1);
  endfunction

  // WORD_ORDER=0 puts the first word at the LSB slot, 1 at the MSB slot.
  function automatic int slot_index(input int ptr, input int n_reg, input bit word_order);
    return word_order ? (n_reg - 1 - ptr) : ptr;
  endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: serial-in / parallel-out packer. Collects R_DATA_WIDTH-bit words
// into an R_DATA_WIDTH*N_REG-bit block and presents it with valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               synchronous abort of the partial or held block
//   in_valid/in_ready   input word handshake (in_ready high only in FILL)
//   in_data, in_last    input word and short-block terminator
//   in_addr, in_addr_en explicit slot addressing (only with WORD_PACKER_ADDR_EN)
//   out_valid/out_ready block handshake (out_valid high only in HOLD)
//   out_data, out_count assembled block and number of words written into it
//
// Build option: define WORD_PACKER_ADDR_EN to add addressed slot writes.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int N_REG_BITS   = ptr_bits(N_REG),
  parameter int CNT_BITS     = cnt_bits(N_REG),
  parameter int WORD_ORDER   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [R_DATA_WIDTH-1:0]         in_data,
  input  logic                            in_last,
`ifdef WORD_PACKER_ADDR_EN
  input  logic [N_REG_BITS-1:0]           in_addr,
  input  logic                            in_addr_en,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [R_DATA_WIDTH*N_REG-1:0]   out_data,
  output logic [CNT_BITS-1:0]             out_count
);

  localparam logic [N_REG_BITS-1:0] LAST_PTR  = N_REG_BITS'(N_REG - 1);
  localparam logic [N_REG_BITS:0]   N_REG_EXT = N_REG[N_REG_BITS:0];
  localparam logic [CNT_BITS-1:0]   N_CNT     = CNT_BITS'(N_REG);

  state_t                          state_reg, state_next;
  logic [N_REG_BITS-1:0]           ptr_reg, ptr_next;
  logic [CNT_BITS-1:0]             count_reg, count_next;
  logic [CNT_BITS-1:0]             out_count_reg, out_count_next;
  logic [R_DATA_WIDTH*N_REG-1:0]   block_reg, block_next;

  logic [N_REG_BITS-1:0]           wr_ptr;   // logical slot targeted by this word
  logic                            wr_ok;    // slot exists; otherwise the word is dropped
  logic [CNT_BITS-1:0]             count_inc;

`ifdef WORD_PACKER_ADDR_EN
  assign wr_ptr = in_addr_en ? in_addr : ptr_reg;
  // With a non-power-of-two N_REG the address field can name slots that do not exist.
  assign wr_ok  = !in_addr_en || ({1'b0, in_addr} < N_REG_EXT);
`else
  assign wr_ptr = ptr_reg;
  assign wr_ok  = 1'b1;
`endif

  // Repeated addressed overwrites could otherwise push the count past N_REG;
  // saturating keeps out_count within 1..N_REG.
  assign count_inc = (count_reg == N_CNT) ? N_CNT : count_reg + CNT_BITS'(1);

  assign in_ready  = (state_reg == FILL);
  assign out_valid = (state_reg == HOLD);
  assign out_data  = block_reg;
  assign out_count = out_count_reg;

  always_comb begin
    int slot;
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    count_next     = count_reg;
    out_count_next = out_count_reg;
    block_next     = block_reg;
    slot           = 0;

    case (state_reg)
      FILL: begin
        if (in_valid && wr_ok) begin
          slot = slot_index(int'(wr_ptr), N_REG, WORD_ORDER != 0);
          block_next[slot*R_DATA_WIDTH +: R_DATA_WIDTH] = in_data;
          count_next = count_inc;
          if (in_last || (wr_ptr == LAST_PTR)) begin
            state_next     = HOLD;
            out_count_next = count_inc;
            ptr_next       = '0;
          end else begin
            ptr_next = wr_ptr + N_REG_BITS'(1);
          end
        end
      end
      HOLD: begin
        // Zeroing here is what makes unwritten slots of a short block read 0.
        if (out_ready) begin
          state_next     = FILL;
          block_next     = '0;
          count_next     = '0;
          out_count_next = '0;
        end
      end
      default: state_next = FILL;
    endcase

    // clear wins over any word offered in the same cycle.
    if (clear) begin
      state_next     = FILL;
      ptr_next       = '0;
      count_next     = '0;
      out_count_next = '0;
      block_next     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      ptr_reg       <= '0;
      count_reg     <= '0;
      out_count_reg <= '0;
      block_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      count_reg     <= count_next;
      out_count_reg <= out_count_next;
      block_reg     <= block_next;
    end
  end

endmodule
